regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with per-register busy scoreboard, the next-generation register file for the pipelined processor. It provides NUM_RD registered read ports and two prioritised write ports, optional write-to-read bypass, optional hardwired-zero register 0, and asynchronous clear. The decode stage sits upstream and reads operands here. Writeback drives the write ports. Issue logic uses the busy bits to detect pending producers.

## Interface
- DATA_W, 64: register width in bits
- DEPTH, 32: number of registers (2..2^ADDR_W)
- ADDR_W, 5: address width
- NUM_RD, 4: number of read ports (1..8)
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads return pre-edge contents
- ZERO_REG, 1: 1 = register 0 reads as 0, never written, never busy
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- rd_en  in  1  common read enable for all read ports
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_busy  out  NUM_RD  registered busy flag per read port
- wr_en1, wr_en2  in  1 each  write enables
- wr_addr1, wr_addr2  in  ADDR_W each  write addresses
- wr_data1, wr_data2  in  DATA_W each  write data
- alloc_en  in  1  mark a register busy (producer issued)
- alloc_addr  in  ADDR_W  register to mark busy
- busy_vec  out  DEPTH  current scoreboard, bit r = register r busy

## Operation
- Storage: DEPTH x DATA_W array plus DEPTH busy bits.
- Writes:
  - On a rising edge, wr_enN writes wr_dataN to wr_addrN.
  - When both ports target the same address, port 1 wins and port 2's data is discarded.
  - Writes to addresses >= DEPTH are ignored.
  - Writes to address 0 are ignored when ZERO_REG=1.
- Busy scoreboard:
  - A write on either port clears the busy bit of its target address.
  - alloc_en sets busy[alloc_addr].
  - When alloc and a write target the same address in the same cycle, the bit ends set, because the new producer wins.
  - alloc to address 0 (when ZERO_REG=1) is ignored; alloc to an address >= DEPTH is ignored.
  - busy_vec is driven directly from the busy flops.
- Reads:
  - When rd_en=1, port i captures the contents of rd_addr[i] into rd_data[i] and busy[rd_addr[i]] into rd_busy[i].
  - When rd_en=0, rd_data and rd_busy hold their previous values.
  - An address >= DEPTH reads as data 0, busy 0.
  - Address 0 reads as 0 and not busy when ZERO_REG=1.
- Bypass with BYPASS=1, when a read address matches an enabled, legal write in the same cycle:
  - rd_data takes the winning write data (port 1 over port 2).
  - rd_busy takes 0, unless a same-cycle alloc hits that address, in which case it takes 1.
- Bypass with BYPASS=0: reads return pre-edge data and pre-edge busy. Same-cycle writes and allocs become visible on the next read.
- A same-cycle alloc with no write to that address is not reflected in rd_busy. It is visible from the next read.

## Timing
- Read latency: 1 cycle. Address and rd_en sampled at edge N, rd_data/rd_busy valid after edge N.
- Write latency: a write at edge N is readable at edge N (BYPASS=1) or edge N+1 (BYPASS=0).
- busy_vec reflects alloc/write at edge N immediately after edge N.
- Reset (rst=1, asynchronous, any time including mid-write):
  - All registers go to 0, all busy bits to 0, rd_data to 0, rd_busy to 0, busy_vec to 0.
  - While rst=1, writes, allocs and reads have no effect.
  - The first edge with rst=0 performs normal operation.
- No handshake. Every enabled operation completes in the cycle presented, so there is no stall or backpressure.

## Test plan
- Reset then read: assert rst mid-cycle after writing 0xDEAD to r5, then rd_en with addr 5 on all ports -> rd_data all 0, rd_busy 0, busy_vec 0.
- Dual-write conflict: wr_en1/wr_en2 both to r7, data1=0x1111, data2=0x2222, then read r7 -> 0x1111. Distinct addresses r3/r4 -> both written.
- Bypass:
  - BYPASS=1: write r9=0xABCD and read r9 in the same cycle -> rd_data=0xABCD after that edge.
  - BYPASS=0, same stimulus: old value (0) first, 0xABCD on the next read.
- Scoreboard:
  - alloc r12 -> busy_vec[12]=1, and a read of r12 next cycle gives rd_busy=1.
  - Write r12 -> bit clears.
  - Same-cycle alloc and write to r12 -> bit stays 1.
- Zero register, ZERO_REG=1: write 0xFFFF to r0 and alloc r0 -> reads 0, busy_vec[0]=0.
- Hold and range:
  - rd_en=0 with changing addresses -> rd_data unchanged.
  - DEPTH=20: write/read r25 -> ignored, read returns 0.
  - NUM_RD=8: all ports read distinct registers correctly in one cycle.

Source files
------------

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Brief    : Read, write, allocate and scoreboard bundle for regfile_mp.
// Revision : 1.0
// ============================================================================
interface regfile_mp_if #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 4
);
    logic                       rd_en;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_busy;

    logic                       wr_en1;
    logic [ADDR_W-1:0]          wr_addr1;
    logic [DATA_W-1:0]          wr_data1;
    logic                       wr_en2;
    logic [ADDR_W-1:0]          wr_addr2;
    logic [DATA_W-1:0]          wr_data2;

    logic                       alloc_en;
    logic [ADDR_W-1:0]          alloc_addr;
    logic [DEPTH-1:0]           busy_vec;

    modport master (
        output rd_en, rd_addr,
        output wr_en1, wr_addr1, wr_data1,
        output wr_en2, wr_addr2, wr_data2,
        output alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_addr,
        input  wr_en1, wr_addr1, wr_data1,
        input  wr_en2, wr_addr2, wr_data2,
        input  alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Brief    : Multi-port register file, two prioritised write ports, busy bits.
// Revision : 1.0
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus_io
);

    localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic            c_ZERO      = (ZERO_REG != 0);
    localparam logic            c_BYP       = (BYPASS != 0);

    // Legal target: inside the array and not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < c_DEPTH_EXT) && !(c_ZERO && (a == '0));
    endfunction

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    logic                     w_wr1_ok, w_wr2_ok, w_alloc_ok;
    logic [DATA_W-1:0]        w_port_data [NUM_RD];
    logic                     w_port_busy [NUM_RD];

    assign w_wr1_ok   = bus_io.wr_en1 && addr_ok(bus_io.wr_addr1);
    // Port 2 is dropped whenever port 1 claims the same register.
    assign w_wr2_ok   = bus_io.wr_en2 && addr_ok(bus_io.wr_addr2) &&
                        !(w_wr1_ok && (bus_io.wr_addr2 == bus_io.wr_addr1));
    assign w_alloc_ok = bus_io.alloc_en && addr_ok(bus_io.alloc_addr);

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (w_wr2_ok) begin
            mem_d[bus_io.wr_addr2]  = bus_io.wr_data2;
            busy_d[bus_io.wr_addr2] = 1'b0;
        end
        if (w_wr1_ok) begin
            mem_d[bus_io.wr_addr1]  = bus_io.wr_data1;
            busy_d[bus_io.wr_addr1] = 1'b0;
        end
        // A new producer outranks the write that retires the old one.
        if (w_alloc_ok) begin
            busy_d[bus_io.alloc_addr] = 1'b1;
        end
    end

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_ok;
            logic              w_hit1;
            logic              w_hit2;
            logic              w_alloc_hit;

            assign w_addr      = bus_io.rd_addr[i*ADDR_W +: ADDR_W];
            assign w_ok        = addr_ok(w_addr);
            assign w_hit1      = c_BYP && w_wr1_ok && (bus_io.wr_addr1 == w_addr);
            assign w_hit2      = c_BYP && w_wr2_ok && (bus_io.wr_addr2 == w_addr);
            assign w_alloc_hit = w_alloc_ok && (bus_io.alloc_addr == w_addr);

            assign w_port_data[i] = !w_ok  ? '0              :
                                    w_hit1 ? bus_io.wr_data1 :
                                    w_hit2 ? bus_io.wr_data2 :
                                             mem_q[w_addr];
            assign w_port_busy[i] = !w_ok             ? 1'b0        :
                                    (w_hit1 || w_hit2) ? w_alloc_hit :
                                                         busy_q[w_addr];
        end
    endgenerate

    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        if (bus_io.rd_en) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_data_d[i*DATA_W +: DATA_W] = w_port_data[i];
                rd_busy_d[i]                  = w_port_busy[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            mem_q     <= mem_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus_io.rd_data  = rd_data_q;
    assign bus_io.rd_busy  = rd_busy_q;
    assign bus_io.busy_vec = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Brief    : Two regfile_mp configurations against a behavioural array model.
// Revision : 1.0
// ============================================================================
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Configuration 0: DEPTH 32, 4 ports, bypass, zero reg.
    // Configuration 1: DEPTH 20, 8 ports, no bypass, no zero reg.
    int cfg_depth [2] = '{32, 20};
    int cfg_nrd   [2] = '{4, 8};
    int cfg_byp   [2] = '{1, 0};
    int cfg_zero  [2] = '{1, 0};

    regfile_mp_if #(.DATA_W(64), .DEPTH(32), .ADDR_W(5), .NUM_RD(4)) if_a ();
    regfile_mp_if #(.DATA_W(64), .DEPTH(20), .ADDR_W(5), .NUM_RD(8)) if_b ();

    regfile_mp #(.DATA_W(64), .DEPTH(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1))
        u_dut_a (.clk(clk), .rst(rst), .bus_io(if_a));
    regfile_mp #(.DATA_W(64), .DEPTH(20), .ADDR_W(5), .NUM_RD(8), .BYPASS(0), .ZERO_REG(0))
        u_dut_b (.clk(clk), .rst(rst), .bus_io(if_b));

    logic        s_rd_en, s_we1, s_we2, s_al;
    logic [4:0]  s_ra [8];
    logic [4:0]  s_wa1, s_wa2, s_aa;
    logic [63:0] s_wd1, s_wd2;

    assign if_a.rd_en      = s_rd_en;
    assign if_a.rd_addr    = {s_ra[3], s_ra[2], s_ra[1], s_ra[0]};
    assign if_a.wr_en1     = s_we1;
    assign if_a.wr_addr1   = s_wa1;
    assign if_a.wr_data1   = s_wd1;
    assign if_a.wr_en2     = s_we2;
    assign if_a.wr_addr2   = s_wa2;
    assign if_a.wr_data2   = s_wd2;
    assign if_a.alloc_en   = s_al;
    assign if_a.alloc_addr = s_aa;

    assign if_b.rd_en      = s_rd_en;
    assign if_b.rd_addr    = {s_ra[7], s_ra[6], s_ra[5], s_ra[4], s_ra[3], s_ra[2], s_ra[1], s_ra[0]};
    assign if_b.wr_en1     = s_we1;
    assign if_b.wr_addr1   = s_wa1;
    assign if_b.wr_data1   = s_wd1;
    assign if_b.wr_en2     = s_we2;
    assign if_b.wr_addr2   = s_wa2;
    assign if_b.wr_data2   = s_wd2;
    assign if_b.alloc_en   = s_al;
    assign if_b.alloc_addr = s_aa;

    // Reference state: register contents, busy bits and the last read result.
    logic [63:0] m_reg  [2][32];
    bit          m_busy [2][32];
    logic [63:0] m_rd   [2][8];
    bit          m_rb   [2][8];

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    function automatic bit legal(int k, logic [4:0] a);
        return (int'(a) < cfg_depth[k]) && !(cfg_zero[k] != 0 && a == 5'd0);
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[k][r]  = '0;
                m_busy[k][r] = 1'b0;
            end
            for (int p = 0; p < 8; p++) begin
                m_rd[k][p] = '0;
                m_rb[k][p] = 1'b0;
            end
        end
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            bit l1, l2, la;
            l1 = s_we1 && legal(k, s_wa1);
            l2 = s_we2 && legal(k, s_wa2);
            la = s_al  && legal(k, s_aa);
            if (s_rd_en) begin
                for (int p = 0; p < cfg_nrd[k]; p++) begin
                    logic [4:0] a;
                    a = s_ra[p];
                    if (!legal(k, a)) begin
                        m_rd[k][p] = '0;
                        m_rb[k][p] = 1'b0;
                    end else if (cfg_byp[k] != 0 && l1 && s_wa1 == a) begin
                        m_rd[k][p] = s_wd1;
                        m_rb[k][p] = la && (s_aa == a);
                    end else if (cfg_byp[k] != 0 && l2 && s_wa2 == a) begin
                        m_rd[k][p] = s_wd2;
                        m_rb[k][p] = la && (s_aa == a);
                    end else begin
                        m_rd[k][p] = m_reg[k][a];
                        m_rb[k][p] = m_busy[k][a];
                    end
                end
            end
            if (l2) begin
                m_reg[k][s_wa2]  = s_wd2;
                m_busy[k][s_wa2] = 1'b0;
            end
            if (l1) begin
                m_reg[k][s_wa1]  = s_wd1;
                m_busy[k][s_wa1] = 1'b0;
            end
            if (la) m_busy[k][s_aa] = 1'b1;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_clear();
        else     model_step();
    end

    function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void compare();
        for (int k = 0; k < 2; k++) begin
            logic [511:0] er, eb, ev, ar, ab, av;
            er = '0; eb = '0; ev = '0;
            for (int p = 0; p < cfg_nrd[k]; p++) begin
                er[p*64 +: 64] = m_rd[k][p];
                eb[p]          = m_rb[k][p];
            end
            for (int r = 0; r < cfg_depth[k]; r++) ev[r] = m_busy[k][r];
            if (k == 0) begin
                ar = 512'(if_a.rd_data);
                ab = 512'(if_a.rd_busy);
                av = 512'(if_a.busy_vec);
            end else begin
                ar = if_b.rd_data;
                ab = 512'(if_b.rd_busy);
                av = 512'(if_b.busy_vec);
            end
            chk($sformatf("cfg%0d rd_data @%0t", k, $time), ar, er);
            chk($sformatf("cfg%0d rd_busy @%0t", k, $time), ab, eb);
            chk($sformatf("cfg%0d busy_vec @%0t", k, $time), av, ev);
        end
    endfunction

    always @(negedge clk) if (chk_en) compare();

    task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
        chk(nm, 512'(act), 512'(exp));
    endtask

    task automatic idle();
        s_rd_en = 1'b0; s_we1 = 1'b0; s_we2 = 1'b0; s_al = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        s_wa1 = '0; s_wa2 = '0; s_aa = '0; s_wd1 = '0; s_wd2 = '0;
        for (int p = 0; p < 8; p++) s_ra[p] = '0;
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Write r5, reset mid-cycle, then read r5 everywhere.
        s_we1 = 1'b1; s_wa1 = 5'd5; s_wd1 = 64'hDEAD;
        tick();
        idle();
        #4 rst = 1'b1;
        tick();
        rst = 1'b0;
        s_rd_en = 1'b1;
        for (int p = 0; p < 8; p++) s_ra[p] = 5'd5;
        tick();
        lit("reset rd_data a", 64'(|if_a.rd_data), 64'd0);
        lit("reset rd_busy a", 64'(if_a.rd_busy), 64'd0);
        lit("reset busy_vec a", 64'(if_a.busy_vec), 64'd0);
        lit("reset rd_data b", 64'(|if_b.rd_data), 64'd0);

        // Same-address dual write: port 1 wins.
        idle();
        s_we1 = 1'b1; s_wa1 = 5'd7; s_wd1 = 64'h1111;
        s_we2 = 1'b1; s_wa2 = 5'd7; s_wd2 = 64'h2222;
        tick();
        idle(); s_rd_en = 1'b1; s_ra[0] = 5'd7;
        tick();
        lit("conflict a", if_a.rd_data[63:0], 64'h1111);
        lit("conflict b", if_b.rd_data[63:0], 64'h1111);

        idle();
        s_we1 = 1'b1; s_wa1 = 5'd3; s_wd1 = 64'h3333;
        s_we2 = 1'b1; s_wa2 = 5'd4; s_wd2 = 64'h4444;
        tick();
        idle(); s_rd_en = 1'b1; s_ra[0] = 5'd3; s_ra[1] = 5'd4;
        tick();
        lit("distinct r3 a", if_a.rd_data[63:0], 64'h3333);
        lit("distinct r4 a", if_a.rd_data[127:64], 64'h4444);
        lit("distinct r4 b", if_b.rd_data[127:64], 64'h4444);

        // Same-cycle write and read of r9.
        idle();
        s_we1 = 1'b1; s_wa1 = 5'd9; s_wd1 = 64'hABCD;
        s_rd_en = 1'b1; s_ra[0] = 5'd9;
        tick();
        lit("bypass a", if_a.rd_data[63:0], 64'hABCD);
        lit("no bypass b", if_b.rd_data[63:0], 64'h0);
        idle(); s_rd_en = 1'b1; s_ra[0] = 5'd9;
        tick();
        lit("no bypass next b", if_b.rd_data[63:0], 64'hABCD);

        // Scoreboard on r12.
        idle(); s_al = 1'b1; s_aa = 5'd12;
        tick();
        lit("alloc bv a", 64'(if_a.busy_vec[12]), 64'd1);
        idle(); s_rd_en = 1'b1; s_ra[0] = 5'd12;
        tick();
        lit("alloc rd_busy a", 64'(if_a.rd_busy[0]), 64'd1);
        lit("alloc rd_busy b", 64'(if_b.rd_busy[0]), 64'd1);
        idle(); s_we1 = 1'b1; s_wa1 = 5'd12; s_wd1 = 64'h12;
        tick();
        lit("write clears a", 64'(if_a.busy_vec[12]), 64'd0);
        idle(); s_we1 = 1'b1; s_wa1 = 5'd12; s_al = 1'b1; s_aa = 5'd12;
        s_rd_en = 1'b1; s_ra[0] = 5'd12;
        tick();
        lit("alloc+write bv a", 64'(if_a.busy_vec[12]), 64'd1);
        lit("alloc+write bv b", 64'(if_b.busy_vec[12]), 64'd1);
        lit("alloc+write bypass busy a", 64'(if_a.rd_busy[0]), 64'd1);
        lit("alloc+write old busy b", 64'(if_b.rd_busy[0]), 64'd0);

        // Register 0: hardwired in cfg0, ordinary in cfg1.
        idle(); s_we1 = 1'b1; s_wa1 = 5'd0; s_wd1 = 64'hFFFF; s_al = 1'b1; s_aa = 5'd0;
        tick();
        lit("zero bv a", 64'(if_a.busy_vec[0]), 64'd0);
        idle(); s_rd_en = 1'b1; s_ra[0] = 5'd0;
        tick();
        lit("zero rd_data a", if_a.rd_data[63:0], 64'h0);
        lit("zero rd_busy a", 64'(if_a.rd_busy[0]), 64'd0);
        lit("r0 rd_data b", if_b.rd_data[63:0], 64'hFFFF);
        lit("r0 rd_busy b", 64'(if_b.rd_busy[0]), 64'd1);

        // Hold while rd_en is low.
        idle(); s_rd_en = 1'b1; s_ra[0] = 5'd7;
        tick();
        idle();
        for (int n = 0; n < 3; n++) begin
            for (int p = 0; p < 8; p++) s_ra[p] = pick();
            tick();
        end
        lit("hold a", if_a.rd_data[63:0], 64'h1111);
        lit("hold b", if_b.rd_data[63:0], 64'h1111);

        // Out of range for DEPTH 20.
        idle(); s_we1 = 1'b1; s_wa1 = 5'd25; s_wd1 = 64'h5555; s_al = 1'b1; s_aa = 5'd25;
        tick();
        idle(); s_rd_en = 1'b1; s_ra[0] = 5'd25;
        tick();
        lit("range data b", if_b.rd_data[63:0], 64'h0);
        lit("range busy b", 64'(if_b.rd_busy[0]), 64'd0);
        lit("range data a", if_a.rd_data[63:0], 64'h5555);

        // Eight distinct reads in one cycle.
        for (int i = 1; i <= 8; i += 2) begin
            idle();
            s_we1 = 1'b1; s_wa1 = 5'(i);     s_wd1 = 64'(32'h100 + i);
            s_we2 = 1'b1; s_wa2 = 5'(i + 1); s_wd2 = 64'(32'h101 + i);
            tick();
        end
        idle(); s_rd_en = 1'b1;
        for (int p = 0; p < 8; p++) s_ra[p] = 5'(p + 1);
        tick();
        for (int p = 0; p < 8; p++)
            lit($sformatf("multi b port%0d", p), if_b.rd_data[p*64 +: 64], 64'(32'h101 + p));

        // Randomised traffic with one asynchronous reset mid-run.
        for (int n = 0; n < 3000; n++) begin
            s_rd_en = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < 8; p++) s_ra[p] = pick();
            s_we1 = $urandom_range(0, 1) == 1; s_wa1 = pick(); s_wd1 = {$urandom, $urandom};
            s_we2 = $urandom_range(0, 1) == 1; s_wa2 = pick(); s_wd2 = {$urandom, $urandom};
            s_al  = $urandom_range(0, 2) == 0; s_aa  = pick();
            tick();
            if (n == 1500) begin
                #4 rst = 1'b1;
                tick(); tick();
                rst = 1'b0;
            end
        end

        idle();
        tick(); tick();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
